// File: rtl/sid_pkg.sv
// Shared constants, output-stage encodings and the voice mixing helper
// for the SID mixer / 1-bit DAC block.
package sid_pkg;

    localparam int VOICE_W  = 12;
    localparam int MIX_W    = 14;
    localparam int SAMPLE_W = 16;
    localparam int PWM_W    = 8;
    localparam int VOL_W    = 4;
    localparam int PROD_W   = MIX_W + VOL_W;

    typedef enum logic [0:0] {
        OUT_DSM = 1'b0,
        OUT_PWM = 1'b1
    } out_mode_e;

    // Three full-scale voices need 14 bits, so this sum can never wrap.
    function automatic logic [MIX_W-1:0] mixVoices(
        input logic [VOICE_W-1:0] v0,
        input logic [VOICE_W-1:0] v1,
        input logic [VOICE_W-1:0] v2,
        input logic [2:0]         mute
    );
        logic [MIX_W-1:0] sum;
        sum = '0;
        if (!mute[0]) sum = sum + MIX_W'(v0);
        if (!mute[1]) sum = sum + MIX_W'(v1);
        if (!mute[2]) sum = sum + MIX_W'(v2);
        return sum;
    endfunction

endpackage

// File: rtl/sid_dac_out.sv
// 1-bit output stage: first-order delta-sigma modulator or fixed-period
// 8-bit PWM, chosen at elaboration time by OUT_MODE.
module sid_dac_out
    import sid_pkg::*;
#(
    parameter int OUT_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_dac
);

    if (OUT_MODE == int'(OUT_PWM)) begin : g_pwm
        logic [PWM_W-1:0] r_count;
        logic [PWM_W-1:0] r_duty;
        logic             r_dac;
        logic             w_unusedLsb;

        assign w_unusedLsb = ^i_sample[SAMPLE_W-PWM_W-1:0];

        // Duty only reloads on the 255->0 wrap so each period stays glitch-free.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_count <= '0;
                r_duty  <= '0;
                r_dac   <= 1'b0;
            end else begin
                r_count <= r_count + PWM_W'(1);
                if (r_count == '1) begin
                    r_duty <= i_sample[SAMPLE_W-1 -: PWM_W];
                end
                r_dac <= (r_count < r_duty);
            end
        end

        assign o_dac = r_dac;
    end else begin : g_dsm
        logic [SAMPLE_W:0] r_acc;

        // The carry out of the 16-bit phase is the pulse-density bit.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else begin
                r_acc <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, i_sample};
            end
        end

        assign o_dac = r_acc[SAMPLE_W];
    end

endmodule

// File: rtl/sid_mixer_dac.sv
// Three-voice mixer with master volume feeding a 1-bit audio output stage.
// Two-stage non-stalling pipeline: capture/sum, then scale by volume.
module sid_mixer_dac
    import sid_pkg::*;
#(
    parameter int OUT_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VOICE_W-1:0]  voice0,
    input  logic [VOICE_W-1:0]  voice1,
    input  logic [VOICE_W-1:0]  voice2,
    input  logic [2:0]          voice_mute,
    input  logic [VOL_W-1:0]    volume,
    input  logic                sample_en,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                dac_out
);

    logic [MIX_W-1:0]    r_mixSum;
    logic [VOL_W-1:0]    r_mixVol;
    logic                r_mixValid;
    logic [SAMPLE_W-1:0] r_sampleOut;
    logic                r_sampleValid;
    logic [PROD_W-1:0]   w_product;
    logic [1:0]          w_unusedProdLsb;

    // Inputs are only looked at on a strobe; anything between strobes is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mixSum   <= '0;
            r_mixVol   <= '0;
            r_mixValid <= 1'b0;
        end else begin
            r_mixValid <= sample_en;
            if (sample_en) begin
                r_mixSum <= mixVoices(voice0, voice1, voice2, voice_mute);
                r_mixVol <= volume;
            end
        end
    end

    assign w_product       = PROD_W'(r_mixSum) * PROD_W'(r_mixVol);
    assign w_unusedProdLsb = w_product[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sampleOut   <= '0;
            r_sampleValid <= 1'b0;
        end else begin
            r_sampleValid <= r_mixValid;
            if (r_mixValid) begin
                r_sampleOut <= w_product[PROD_W-1:2];
            end
        end
    end

    assign sample_out   = r_sampleOut;
    assign sample_valid = r_sampleValid;

    sid_dac_out #(
        .OUT_MODE (OUT_MODE)
    ) u_dacOut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (r_sampleOut),
        .o_dac    (dac_out)
    );

endmodule

// File: tb/tb_sid_mixer_dac.sv
// Self-checking bench: both output-stage variants driven in parallel and
// compared against a transaction-level model of the mixer and DAC densities.
module tb_sid_mixer_dac;

    logic        clk;
    logic        rst_n;
    logic [11:0] voice0;
    logic [11:0] voice1;
    logic [11:0] voice2;
    logic [2:0]  voice_mute;
    logic [3:0]  volume;
    logic        sample_en;

    logic [15:0] sampleOutDsm;
    logic        sampleValidDsm;
    logic        dacDsm;
    logic [15:0] sampleOutPwm;
    logic        sampleValidPwm;
    logic        dacPwm;

    typedef struct {
        int          due;
        logic [15:0] val;
    } pend_t;

    pend_t       pend[$];
    int          nVectors;
    int          nMiscompares;
    int          edgeCount;
    logic [15:0] expSample;
    logic        expValid;
    int          pwmK;
    int          pwmHigh;
    int          pwmDuty;
    logic        dsmObs;

    sid_mixer_dac #(.OUT_MODE(0)) dutDsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .voice0       (voice0),
        .voice1       (voice1),
        .voice2       (voice2),
        .voice_mute   (voice_mute),
        .volume       (volume),
        .sample_en    (sample_en),
        .sample_out   (sampleOutDsm),
        .sample_valid (sampleValidDsm),
        .dac_out      (dacDsm)
    );

    sid_mixer_dac #(.OUT_MODE(1)) dutPwm (
        .clk          (clk),
        .rst_n        (rst_n),
        .voice0       (voice0),
        .voice1       (voice1),
        .voice2       (voice2),
        .voice_mute   (voice_mute),
        .volume       (volume),
        .sample_en    (sample_en),
        .sample_out   (sampleOutPwm),
        .sample_valid (sampleValidPwm),
        .dac_out      (dacPwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance the model by one edge, check 1 ns after the edge.
    task automatic applyStimulus(input logic en, input logic [11:0] a, input logic [11:0] b,
                                 input logic [11:0] c, input logic [2:0] m,
                                 input logic [3:0] vol, input logic rn);
        int          sumv;
        logic [15:0] prevSample;
        sample_en  = en;
        voice0     = a;
        voice1     = b;
        voice2     = c;
        voice_mute = m;
        volume     = vol;
        rst_n      = rn;
        @(posedge clk);
        edgeCount++;
        prevSample = expSample;
        expValid   = 1'b0;
        if (!rn) begin
            pend.delete();
            expSample = '0;
            pwmK      = 0;
            pwmHigh   = 0;
            pwmDuty   = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == edgeCount) begin
                expSample = pend[0].val;
                expValid  = 1'b1;
                void'(pend.pop_front());
            end
            if (en) begin
                sumv = (m[0] ? 0 : int'(a)) + (m[1] ? 0 : int'(b)) + (m[2] ? 0 : int'(c));
                pend.push_back('{due: edgeCount + 1, val: 16'((sumv * int'(vol)) / 4)});
            end
            pwmK++;
        end
        #1;
        checkOutput("validDsm", 32'(sampleValidDsm), 32'(expValid));
        checkOutput("sampleDsm", 32'(sampleOutDsm), 32'(expSample));
        checkOutput("validPwm", 32'(sampleValidPwm), 32'(expValid));
        checkOutput("samplePwm", 32'(sampleOutPwm), 32'(expSample));
        dsmObs = dacDsm;
        if (!rn) begin
            checkOutput("resetDacDsm", 32'(dacDsm), 32'd0);
            checkOutput("resetDacPwm", 32'(dacPwm), 32'd0);
        end else begin
            pwmHigh += int'(dacPwm);
            if (pwmK % 256 == 0) begin
                checkOutput("pwmPeriodHigh", 32'(pwmHigh), 32'(pwmDuty));
                pwmHigh = 0;
                pwmDuty = int'(prevSample[15:8]);
            end
        end
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 12'($urandom), 12'($urandom), 12'($urandom),
                      3'($urandom), 4'($urandom), 1'b1);
    endtask

    // Over 256 cycles of a constant level x, the carry count is x/256 rounded down or up.
    task automatic dsmWindow(input string tag, input int x);
        int ones;
        int lo;
        int hi;
        ones = 0;
        lo   = (x * 256) / 65536;
        hi   = lo + ((x % 256 != 0) ? 1 : 0);
        for (int i = 0; i < 256; i++) begin
            idleStep();
            ones += int'(dsmObs);
        end
        nVectors++;
        assert (ones >= lo && ones <= hi)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %0d ones expected %0d..%0d", tag, ones, lo, hi);
        end
    endtask

    initial begin
        int ones;
        nVectors     = 0;
        nMiscompares = 0;
        edgeCount    = 0;
        expSample    = '0;
        expValid     = 1'b0;
        pwmK         = 0;
        pwmHigh      = 0;
        pwmDuty      = 0;
        dsmObs       = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 12'($urandom), 3'd0, 4'd15, 1'b0);
        end
        checkOutput("resetSample", 32'(sampleOutDsm), 32'd0);
        checkOutput("resetValid", 32'(sampleValidDsm), 32'd0);

        // Full-scale voices at full volume.
        applyStimulus(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 3'b000, 4'd15, 1'b1);
        checkOutput("fullScaleEarly", 32'(sampleValidDsm), 32'd0);
        idleStep();
        checkOutput("fullScaleValid", 32'(sampleValidDsm), 32'd1);
        checkOutput("fullScaleSample", 32'(sampleOutDsm), 32'h0000B3F4);
        idleStep();
        idleStep();
        dsmWindow("dsmDensityB3F4", 16'hB3F4);

        // Voice 2 muted, half-scale voices, volume 8.
        applyStimulus(1'b1, 12'h800, 12'h800, 12'h800, 3'b100, 4'd8, 1'b1);
        idleStep();
        checkOutput("muteSample", 32'(sampleOutDsm), 32'h00002000);
        idleStep();
        idleStep();
        dsmWindow("dsmDensity2000", 16'h2000);

        // Volume zero silences the delta-sigma output completely.
        applyStimulus(1'b1, 12'($urandom), 12'($urandom), 12'($urandom), 3'd0, 4'd0, 1'b1);
        idleStep();
        checkOutput("volZeroSample", 32'(sampleOutDsm), 32'd0);
        idleStep();
        idleStep();
        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            idleStep();
            ones += int'(dsmObs);
        end
        checkOutput("volZeroDacOnes", 32'(ones), 32'd0);

        // PWM: duty 0x40, then a mid-period load of 0xB3 takes effect at the next wrap.
        applyStimulus(1'b1, 12'hFFF, 12'hFFF, 12'h002, 3'b000, 4'd8, 1'b1);
        idleStep();
        checkOutput("pwmSample4000", 32'(sampleOutPwm), 32'h00004000);
        for (int i = 0; i < 430; i++) idleStep();
        applyStimulus(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 3'b000, 4'd15, 1'b1);
        for (int i = 0; i < 600; i++) idleStep();

        // Back-to-back random strobes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), 12'($urandom),
                          3'($urandom), 4'($urandom), 1'b1);
        end

        // Strobe in flight when reset asserts is discarded.
        applyStimulus(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 3'b000, 4'd15, 1'b1);
        applyStimulus(1'b0, 12'h0, 12'h0, 12'h0, 3'b000, 4'd0, 1'b0);
        applyStimulus(1'b0, 12'h0, 12'h0, 12'h0, 3'b000, 4'd0, 1'b1);
        checkOutput("flushValid", 32'(sampleValidDsm), 32'd0);
        checkOutput("flushSample", 32'(sampleOutDsm), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 12'($urandom),
                          3'($urandom), 4'($urandom), 1'b1);
        end
        for (int i = 0; i < 3; i++) idleStep();

        // Random mix with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), 12'($urandom),
                          3'($urandom), 4'($urandom), 1'($urandom_range(0, 99) != 0));
        end
        for (int i = 0; i < 300; i++) idleStep();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
